wave_play_sequencer: RTL and testbench

Control block for the 256-entry waveform converter datapath. It synchronizes the user waveform-select switches, validates the one-hot mode and drives the converter's mode select. It waits for the converter buffer to settle, then streams sample addresses 0..255 to the DAC path at a programmable rate over a valid/ready handshake. It sits between the board switches and the converter/DAC output stage.

---
 rtl/wave_pkg.sv | 32 +++
 rtl/wave_play_sequencer_if.sv | 29 ++
 rtl/wave_sw_sync.sv | 62 ++++++
 rtl/wave_play_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_wave_play_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wave_pkg
// Purpose  : Mode codes, sweep constants and FSM state type shared by the
//            waveform playback sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package wave_pkg;

    localparam logic [3:0] MODE_NONE   = 4'b0000;
    localparam logic [3:0] MODE_SINE   = 4'b0001;
    localparam logic [3:0] MODE_TRI    = 4'b0010;
    localparam logic [3:0] MODE_SQUARE = 4'b0100;
    localparam logic [3:0] MODE_FM     = 4'b1000;

    localparam int N_SAMPLES     = 256;
    localparam int SETTLE_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_PLAY   = 2'd3
    } state_t;

    function automatic logic is_valid_mode(input logic [3:0] v);
        return (v == MODE_SINE) || (v == MODE_TRI) ||
               (v == MODE_SQUARE) || (v == MODE_FM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wave_play_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : wave_play_sequencer_if
// Purpose  : Sample-address stream from the sequencer to the DAC path.
// Revision : 1.0 - initial release
// ============================================================================
interface wave_play_sequencer_if;

    logic [7:0] sample_addr;
    logic       sample_valid;
    logic       sample_ready;
    logic       wrap;

    modport master (
        output sample_addr,
        output sample_valid,
        output wrap,
        input  sample_ready
    );

    modport slave (
        input  sample_addr,
        input  sample_valid,
        input  wrap,
        output sample_ready
    );

endinterface
`default_nettype wire

// File: rtl/wave_sw_sync.sv
`default_nettype none
// ============================================================================
// Module   : wave_sw_sync
// Purpose  : Two-flop synchronizer for the mode switches, with an optional
//            stability filter enabled by WAVE_PLAY_SEQ_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wave_sw_sync #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [3:0] sw_raw,
    output logic      [3:0] sw_stable
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 4'b0000;
            r_sync <= 4'b0000;
        end else begin
            r_meta <= sw_raw;
            r_sync <= r_meta;
        end
    end

`ifdef WAVE_PLAY_SEQ_DEBOUNCE_EN
    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [3:0]         r_cand;
    logic [3:0]         r_stable;
    logic [c_CNT_W-1:0] r_cnt;

    // Any change of the synchronized value restarts the stability count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand   <= 4'b0000;
            r_stable <= 4'b0000;
            r_cnt    <= '0;
        end else if (r_sync != r_cand) begin
            r_cand <= r_sync;
            r_cnt  <= '0;
        end else if (r_cnt == c_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= r_cand;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign sw_stable = r_stable;
`else
    logic w_unused_debounce;

    assign w_unused_debounce = (DEBOUNCE_CYCLES != 0);
    assign sw_stable         = r_sync;
`endif

endmodule
`default_nettype wire

// File: rtl/wave_play_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wave_play_sequencer
// Purpose  : Selects the converter mode from the switches and streams buffer
//            addresses 0..255 at a programmable rate (WAVE_PLAY_SEQ_DEBOUNCE_EN
//            adds switch debounce inside wave_sw_sync).
// Revision : 1.0 - initial release
// ============================================================================
module wave_play_sequencer
    import wave_pkg::*;
#(
    parameter int DIV_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [3:0]       sw_raw,
    input  wire logic             enable,
    input  wire logic [DIV_W-1:0] rate_div,
    output logic      [3:0]       conv_sel,
    output logic                  conv_load,
    output logic                  busy,
    output logic                  mode_err,
    output logic                  underrun,
    wave_play_sequencer_if.master smp
);

    localparam logic [7:0] c_LAST_ADDR  = 8'(N_SAMPLES - 1);
    localparam logic [1:0] c_SETTLE_END = 2'(SETTLE_CYCLES - 1);

    logic [3:0] w_sw;

    wave_sw_sync #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_sync (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .sw_stable (w_sw)
    );

    state_t           r_state, w_state_nx;
    logic [3:0]       r_conv_sel, w_conv_sel_nx;
    logic             r_conv_load, w_conv_load_nx;
    logic [7:0]       r_addr, w_addr_nx;
    logic             r_valid, w_valid_nx;
    logic             r_wrap, w_wrap_nx;
    logic             r_busy, w_busy_nx;
    logic             r_mode_err, w_mode_err_nx;
    logic             r_underrun, w_underrun_nx;
    logic [3:0]       r_target, w_target;
    logic             r_exit, w_exit_nx;
    logic [DIV_W-1:0] r_cnt, w_cnt_nx;
    logic [1:0]       r_settle, w_settle_nx;

    logic w_valid_sw;
    logic w_change;
    logic w_hs;
    logic w_tick;
    logic w_load;
    logic w_play;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_valid_sw     = is_valid_mode(w_sw);
        // Last valid switch value wins; invalid values leave the target alone.
        w_target       = w_valid_sw ? w_sw : r_target;
        w_change       = (w_target != r_conv_sel);
        w_hs           = r_valid & smp.sample_ready;
        // >= keeps the counter bounded if rate_div is lowered mid-period.
        w_tick         = (r_cnt >= rate_div);

        w_state_nx     = r_state;
        w_conv_sel_nx  = r_conv_sel;
        w_conv_load_nx = 1'b0;
        w_addr_nx      = r_addr;
        w_valid_nx     = r_valid;
        w_wrap_nx      = 1'b0;
        w_mode_err_nx  = ~w_valid_sw;
        w_underrun_nx  = r_underrun;
        w_exit_nx      = r_exit;
        w_cnt_nx       = r_cnt;
        w_settle_nx    = r_settle;
        w_load         = 1'b0;
        w_play         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable && (w_target != MODE_NONE)) begin
                    w_load = 1'b1;
                end
            end
            ST_LOAD: begin
                w_state_nx  = ST_SETTLE;
                w_settle_nx = 2'd0;
            end
            ST_SETTLE: begin
                if (r_settle == c_SETTLE_END) begin
                    if (!enable) begin
                        w_state_nx = ST_IDLE;
                    end else if (w_change) begin
                        w_load = 1'b1;
                    end else begin
                        w_play = 1'b1;
                    end
                end else begin
                    w_settle_nx = r_settle + 2'd1;
                end
            end
            ST_PLAY: begin
                if (w_hs) begin
                    w_valid_nx = 1'b0;
                    w_addr_nx  = r_addr + 8'd1;
                    w_wrap_nx  = (r_addr == c_LAST_ADDR);
                end
                if (!enable || w_change || r_exit) begin
                    if (!r_valid || w_hs) begin
                        w_exit_nx = 1'b0;
                        if (enable) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nx = ST_IDLE;
                        end
                    end else begin
                        w_exit_nx = 1'b1;
                    end
                end else begin
                    w_cnt_nx = w_tick ? '0 : r_cnt + DIV_W'(1);
                    // A tick coinciding with acceptance is dropped silently;
                    // only a sample left waiting counts as an underrun.
                    if (w_tick) begin
                        if (!r_valid) begin
                            w_valid_nx = 1'b1;
                        end else if (!w_hs) begin
                            w_underrun_nx = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nx     = ST_LOAD;
            w_conv_sel_nx  = w_target;
            w_conv_load_nx = 1'b1;
            w_addr_nx      = 8'd0;
            w_valid_nx     = 1'b0;
            w_underrun_nx  = 1'b0;
            w_exit_nx      = 1'b0;
        end
        // Entering PLAY acts as the preloaded first tick.
        if (w_play) begin
            w_state_nx = ST_PLAY;
            w_valid_nx = 1'b1;
            w_cnt_nx   = '0;
        end

        w_busy_nx = (w_state_nx != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conv_sel  <= MODE_NONE;
            r_conv_load <= 1'b0;
            r_addr      <= 8'd0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_busy      <= 1'b0;
            r_mode_err  <= 1'b0;
            r_underrun  <= 1'b0;
            r_target    <= MODE_NONE;
            r_exit      <= 1'b0;
            r_cnt       <= '0;
            r_settle    <= 2'd0;
        end else begin
            r_conv_sel  <= w_conv_sel_nx;
            r_conv_load <= w_conv_load_nx;
            r_addr      <= w_addr_nx;
            r_valid     <= w_valid_nx;
            r_wrap      <= w_wrap_nx;
            r_busy      <= w_busy_nx;
            r_mode_err  <= w_mode_err_nx;
            r_underrun  <= w_underrun_nx;
            r_target    <= w_target;
            r_exit      <= w_exit_nx;
            r_cnt       <= w_cnt_nx;
            r_settle    <= w_settle_nx;
        end
    end

    assign conv_sel         = r_conv_sel;
    assign conv_load        = r_conv_load;
    assign busy             = r_busy;
    assign mode_err         = r_mode_err;
    assign underrun         = r_underrun;
    assign smp.sample_addr  = r_addr;
    assign smp.sample_valid = r_valid;
    assign smp.wrap         = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_wave_play_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_play_sequencer
// Purpose  : Self-checking bench: mode/address scoreboard plus directed
//            latency, stall, mode-change and reset scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_play_sequencer;
    import wave_pkg::*;

    localparam int DIV_W   = 16;
    localparam int W_LOAD  = 0;
    localparam int W_VALID = 1;
    localparam int W_IDLE  = 2;
    localparam int W_EMPTY = 3;
    localparam int W_ACC   = 4;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic [3:0]       sw_raw   = 4'b0000;
    logic             enable   = 1'b0;
    logic [DIV_W-1:0] rate_div = '0;
    logic [3:0]       conv_sel;
    logic             conv_load, busy, mode_err, underrun;

    wave_play_sequencer_if bus();

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_wraps  = 0;

    logic [3:0] q_mode[$];
    logic [3:0] model_mode = MODE_NONE;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wave_play_sequencer #(
        .DIV_W           (DIV_W),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .enable    (enable),
        .rate_div  (rate_div),
        .conv_sel  (conv_sel),
        .conv_load (conv_load),
        .busy      (busy),
        .mode_err  (mode_err),
        .underrun  (underrun),
        .smp       (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int what, input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            case (what)
                W_LOAD:  ok = conv_load;
                W_VALID: ok = bus.sample_valid;
                W_IDLE:  ok = !busy;
                W_EMPTY: ok = (q_mode.size() == 0);
                default: ok = bus.sample_valid && bus.sample_ready;
            endcase
        end
        if (!ok) timeout(name);
    endtask

    task automatic check_spacing(input int n, input int gap, input string name);
        int last  = -1;
        int got   = 0;
        int guard = 0;
        while (got < n && guard < n * (gap + 1) * 2 + 50) begin
            @(negedge clk);
            guard++;
            if (bus.sample_valid && bus.sample_ready) begin
                if (last >= 0) chk(name, cyc - last, gap);
                last = cyc;
                got++;
            end
        end
        if (got < n) timeout(name);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_conv_sel"},  conv_sel,         0);
        chk({tag, "_conv_load"}, conv_load,        0);
        chk({tag, "_addr"},      bus.sample_addr,  0);
        chk({tag, "_valid"},     bus.sample_valid, 0);
        chk({tag, "_wrap"},      bus.wrap,         0);
        chk({tag, "_busy"},      busy,             0);
        chk({tag, "_mode_err"},  mode_err,         0);
        chk({tag, "_underrun"},  underrun,         0);
    endtask

    // Scoreboard: every load must match the next expected mode, and accepted
    // addresses must count up from 0 after each load, wrapping at 255.
    initial begin
        logic [7:0] exp_addr  = 8'd0;
        logic       wrap_due  = 1'b0;
        logic       prev_pend = 1'b0;
        logic [7:0] prev_addr = 8'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_addr  = 8'd0;
                wrap_due  = 1'b0;
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("valid_held", bus.sample_valid, 1);
                    chk("addr_held", bus.sample_addr, prev_addr);
                end
                if (bus.wrap || wrap_due) chk("wrap", bus.wrap, wrap_due);
                if (bus.wrap) n_wraps++;
                wrap_due = 1'b0;
                if (conv_load) begin
                    if (q_mode.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_load: actual conv_sel=%0d required no load", conv_sel);
                    end else begin
                        chk("conv_sel", conv_sel, q_mode.pop_front());
                    end
                    exp_addr = 8'd0;
                end
                if (bus.sample_valid && bus.sample_ready) begin
                    chk("accepted_addr", bus.sample_addr, exp_addr);
                    wrap_due = (exp_addr == 8'hFF);
                    exp_addr = exp_addr + 8'd1;
                end
                prev_pend = bus.sample_valid && !bus.sample_ready;
                prev_addr = bus.sample_addr;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         t0;
        int         w0;
        logic [7:0] held;
        logic [3:0] nsw;
        int         r;

        bus.sample_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check_reset("reset");
        step();
        rst = 1'b0;
        repeat (3) step();

        // Startup latency and rate_div=0 throughput.
        sw_raw = MODE_SINE; enable = 1'b1; rate_div = 0;
        q_mode.push_back(MODE_SINE); model_mode = MODE_SINE;
        t0 = cyc;
        wait_until(W_LOAD, 20, "first_load");
        chk("load_latency", cyc - t0, 3);
        chk("busy_in_load", busy, 1);
        wait_until(W_VALID, 20, "first_valid");
        chk("valid_latency", cyc - t0, 6);
        check_spacing(6, 2, "gap_rate0");

        // Full sweep at rate_div=3 from a fresh load of the held mode.
        step(); enable = 1'b0;
        wait_until(W_IDLE, 20, "disable_to_idle");
        step(); rate_div = 3; enable = 1'b1;
        q_mode.push_back(MODE_SINE);
        w0 = n_wraps;
        check_spacing(256, 4, "gap_rate3");
        repeat (2) @(negedge clk);
        chk("wrap_count", n_wraps - w0, 1);
        wait_until(W_ACC, 10, "post_wrap_accept");
        chk("addr_after_wrap", bus.sample_addr, 0);

        // Downstream stall at rate_div=1.
        step(); rate_div = 1; bus.sample_ready = 1'b0;
        wait_until(W_VALID, 10, "stall_valid_wait");
        held = bus.sample_addr;
        repeat (10) @(negedge clk);
        chk("stall_valid", bus.sample_valid, 1);
        chk("stall_addr", bus.sample_addr, held);
        chk("underrun_set", underrun, 1);
        step(); bus.sample_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_hs", bus.sample_valid && bus.sample_ready, 1);
        chk("stall_release_addr", bus.sample_addr, held);

        // Invalid multi-bit switch value.
        step(); sw_raw = 4'b0110;
        repeat (6) @(negedge clk);
        chk("mode_err_set", mode_err, 1);
        chk("conv_sel_kept", conv_sel, MODE_SINE);
        chk("busy_kept", busy, 1);
        check_spacing(4, 2, "gap_during_err");
        step(); sw_raw = MODE_SINE;
        repeat (6) @(negedge clk);
        chk("mode_err_clear", mode_err, 0);

        // Mode change while a sample is pending.
        step(); bus.sample_ready = 1'b0;
        wait_until(W_VALID, 10, "pend_valid_wait");
        held = bus.sample_addr;
        step(); sw_raw = MODE_SQUARE;
        q_mode.push_back(MODE_SQUARE); model_mode = MODE_SQUARE;
        repeat (6) @(negedge clk);
        chk("pend_conv_sel_old", conv_sel, MODE_SINE);
        chk("pend_valid", bus.sample_valid, 1);
        chk("pend_addr", bus.sample_addr, held);
        step(); bus.sample_ready = 1'b1;
        @(negedge clk);
        chk("pend_accept", bus.sample_valid && bus.sample_ready, 1);
        chk("pend_accept_addr", bus.sample_addr, held);
        wait_until(W_LOAD, 5, "change_load");
        chk("underrun_cleared", underrun, 0);
        chk("load_addr_zero", bus.sample_addr, 0);
        check_spacing(4, 2, "gap_after_change");

        // Randomized ready, rate and switch traffic.
        for (int c = 0; c < 3000; c++) begin
            step();
            bus.sample_ready = ($urandom_range(0, 3) != 0);
            if (c % 150 == 0) rate_div = DIV_W'($urandom_range(0, 3));
            if (c % 50 == 25) begin
                r = $urandom_range(0, 5);
                case (r)
                    0:       nsw = MODE_SINE;
                    1:       nsw = MODE_TRI;
                    2:       nsw = MODE_SQUARE;
                    3:       nsw = MODE_FM;
                    4:       nsw = MODE_NONE;
                    default: nsw = 4'b1010;
                endcase
                sw_raw = nsw;
                if (r < 4 && nsw != model_mode) begin
                    q_mode.push_back(nsw);
                    model_mode = nsw;
                end
            end
        end
        step(); bus.sample_ready = 1'b1;
        wait_until(W_EMPTY, 60, "random_loads_drained");
        repeat (10) step();
        sw_raw = model_mode;
        repeat (6) step();

        // Asynchronous reset during playback.
        chk("busy_before_reset", busy, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset("async_reset");
        q_mode.delete();
        model_mode = MODE_NONE;
        sw_raw = MODE_TRI; enable = 1'b1; rate_div = 2;
        repeat (2) step();
        rst = 1'b0;
        t0 = cyc;
        q_mode.push_back(MODE_TRI); model_mode = MODE_TRI;
        wait_until(W_LOAD, 20, "reload_after_reset");
        chk("reload_latency", cyc - t0, 3);
        check_spacing(4, 3, "gap_after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
